// File: rtl/edp_diag_pkg.sv
// edp_diag_pkg: sequencer states, EDP register selectors and default function group
package edp_diag_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_SAMPLE, S_RECOVER} state_t;
    localparam logic [2:0] SEL_AR  = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_MQ  = 3'd2;
    localparam logic [2:0] SEL_FM  = 3'd3;
    localparam logic [2:0] SEL_BRX = 3'd4;
    localparam logic [2:0] SEL_ARX = 3'd5;
    localparam logic [2:0] SEL_ADX = 3'd6;
    localparam logic [2:0] SEL_AD  = 3'd7;
    localparam logic [3:0] FUNC_GROUP_DEF = 4'b0101;
endpackage

// File: rtl/diag_cycle_counter.sv
// diag_cycle_counter: loadable down-counter that holds at zero
module diag_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - W'(1);
endmodule

// File: rtl/edp_diag_reader.sv
// edp_diag_reader: sequences EBUS diagnostic reads of one or all eight EDP datapath registers
module edp_diag_reader
    import edp_diag_pkg::*;
#(
    parameter logic [3:0] FUNC_GROUP  = FUNC_GROUP_DEF,
    parameter int         SETUP_CYC   = 2,
    parameter int         SETTLE_CYC  = 2,
    parameter int         TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        sweep,
    input  logic [2:0]  sel,
    input  logic        drivingEBUS,
    input  logic [0:35] EBUS,
    output logic [0:8]  diag,
    output logic        diagReadFunc12X,
    output logic        busy,
    output logic        rdValid,
    output logic [0:35] rdData,
    output logic [2:0]  rdSel,
    output logic        done,
    output logic        timeoutErr
);
    state_t     state, state_n;
    logic [2:0] cur;
    logic       sweeping, err_done, last, zero, load, cap, fail;
    logic [7:0] load_val, count;

    diag_cycle_counter #(.W(8)) u_cnt (
        .clk(clk), .reset(reset), .load(load), .value(load_val), .count(count)
    );

    assign zero = count == 8'd0;
    assign last = !sweeping || cur == SEL_AD;

    // Capture lands on the edge into the final settle cycle so rdValid shows during it
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = 8'(SETUP_CYC - 1);
        cap      = 1'b0;
        fail     = 1'b0;
        case (state)
            S_IDLE:    if (req) begin
                           state_n = S_SETUP;
                           load    = 1'b1;
                       end
            S_SETUP:   if (zero) begin
                           state_n  = S_STROBE;
                           load     = 1'b1;
                           load_val = 8'(TIMEOUT_CYC - 1);
                       end
            S_STROBE:  if (drivingEBUS) begin
                           state_n  = S_SAMPLE;
                           load     = 1'b1;
                           load_val = 8'(SETTLE_CYC - 1);
                           cap      = SETTLE_CYC == 1;
                       end else fail = zero;
            S_SAMPLE:  if (zero) state_n = S_RECOVER;
                       else if (!drivingEBUS) fail = 1'b1;
                       else cap = count == 8'd1;
            S_RECOVER: begin
                           state_n = last ? S_IDLE : S_SETUP;
                           load    = !last;
                       end
            default:   state_n = S_IDLE;
        endcase
        if (fail) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= S_IDLE;
            cur        <= '0;
            sweeping   <= 1'b0;
            err_done   <= 1'b0;
            rdValid    <= 1'b0;
            rdData     <= '0;
            rdSel      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state    <= state_n;
            err_done <= fail;
            rdValid  <= cap;
            if (state == S_IDLE && req) begin
                cur        <= sweep ? SEL_AR : sel;
                sweeping   <= sweep;
                timeoutErr <= 1'b0;
            end
            if (state == S_RECOVER && !last) cur <= cur + 3'd1;
            if (fail) timeoutErr <= 1'b1;
            if (cap) begin
                rdData <= EBUS;
                rdSel  <= cur;
            end
        end

    assign busy            = state != S_IDLE;
    assign diagReadFunc12X = state == S_STROBE || state == S_SAMPLE;
    assign diag            = (state == S_SETUP || diagReadFunc12X) ? {FUNC_GROUP, cur, 2'b00} : '0;
    assign done            = err_done || (state == S_RECOVER && last);
endmodule

// File: tb/tb_edp_diag_reader.sv
// tb_edp_diag_reader: randomized bench with a reactive EDP model and a cycle-timeline reference
module tb_edp_diag_reader;
    import edp_diag_pkg::*;
    localparam int SETUP = 2, SETTLE = 2, TMO = 16;
    typedef struct {int c; logic [2:0] s; logic [35:0] d;} ev_t;

    logic        clk = 1'b0, reset, req, sweep, drivingEBUS;
    logic        diagReadFunc12X, busy, rdValid, done, timeoutErr;
    logic [2:0]  sel, rdSel;
    logic [0:35] EBUS, rdData;
    logic [0:8]  diag;
    int          cyc, nchk, nerr, c0, shi, dz, idle_at, exp_done, exp_idle, scnt, drop_sel, wmode;
    bit          no_drive, exp_err;
    logic        terr0;
    logic [2:0]  dsel;
    logic [3:0]  dfg;
    int          kv[8];
    logic [35:0] rw[8];
    ev_t         obs[$], expq[$];
    int          dones[$];

    edp_diag_reader dut (
        .clk(clk), .reset(reset), .req(req), .sweep(sweep), .sel(sel),
        .drivingEBUS(drivingEBUS), .EBUS(EBUS), .diag(diag),
        .diagReadFunc12X(diagReadFunc12X), .busy(busy), .rdValid(rdValid),
        .rdData(rdData), .rdSel(rdSel), .done(done), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [35:0] word(input logic [2:0] s);
        return wmode == 0 ? 36'o123456701234 : wmode == 1 ? 36'(s) * 36'o010101010101 : rw[s];
    endfunction

    // EDP: drives EBUS k cycles after the strobe rises, optionally letting go one cycle later
    initial begin
        logic [2:0] cs;
        bit drv;
        drivingEBUS = 1'b0;
        EBUS = '0;
        forever begin
            @(negedge clk);
            scnt = diagReadFunc12X ? scnt + 1 : 0;
            cs = diag[4:6];
            drv = !no_drive && scnt >= kv[cs] + 1 && !(drop_sel == int'(cs) && scnt >= kv[cs] + 2);
            drivingEBUS = drv;
            EBUS = drv ? word(cs) : {4'($urandom), $urandom};
        end
    end

    task automatic predict(input bit sw, input logic [2:0] s);
        int t = c0;
        expq.delete();
        exp_err = 1'b0;
        for (int n = 0; n < (sw ? 8 : 1); n++) begin
            logic [2:0] cs = sw ? 3'(n) : s;
            int st = t + SETUP + 1;
            if (no_drive || drop_sel == int'(cs)) begin
                exp_err  = 1'b1;
                exp_done = no_drive ? st + TMO : st + kv[cs] + 2;
                exp_idle = exp_done;
                return;
            end
            expq.push_back('{st + kv[cs] + SETTLE, cs, word(cs)});
            t = st + kv[cs] + SETTLE + 1;
        end
        exp_done = t;
        exp_idle = t + 1;
    endtask

    task automatic run(input bit sw, input logic [2:0] s, input bit now, input int extra);
        if (!now) @(negedge clk);
        req = 1'b1; sweep = sw; sel = s; c0 = cyc;
        obs.delete(); dones.delete();
        shi = 0; dz = 0; idle_at = -1; dsel = 'x; dfg = 'x;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 0) terr0 = timeoutErr;
            if (rdValid) obs.push_back('{cyc, rdSel, rdData});
            if (done) dones.push_back(cyc);
            if (diagReadFunc12X) begin shi++; dsel = diag[4:6]; dfg = diag[0:3]; end
            if (busy && diag == '0) dz++;
            req = i == extra;
            if (i == extra) begin sel = ~s; sweep = ~sw; end
            if (!busy) begin idle_at = cyc; break; end
        end
        if (idle_at < 0) begin
            nchk++; nerr++;
            $display("FAIL run_budget: busy=%b after 600 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 1'b0; sweep = 1'b0; sel = '0;
        no_drive = 1'b0; drop_sel = -1; wmode = 0;
        for (int i = 0; i < 8; i++) kv[i] = 1;
        repeat (3) @(negedge clk);
        nchk++;
        if ({diag, diagReadFunc12X, busy, rdValid, done, timeoutErr} !== 14'b0) begin
            nerr++;
            $display("FAIL reset_ctl: got %b required 0", {diag, diagReadFunc12X, busy, rdValid, done, timeoutErr});
        end
        nchk++;
        if (rdData !== '0 || rdSel !== '0) begin
            nerr++; $display("FAIL reset_data: got %o/%0d required 0/0", rdData, rdSel);
        end
        reset = 1'b0;
        @(negedge clk);
        nchk++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL reset_release_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_arx;
        wmode = 0;
        run(1'b0, SEL_ARX, 1'b0, -1);
        nchk++;
        if (obs.size() != 1) begin nerr++; $display("FAIL arx_count: got %0d required 1", obs.size()); end
        else begin
            nchk++;
            if (obs[0].c - c0 != 6) begin nerr++; $display("FAIL arx_latency: got %0d required 6", obs[0].c - c0); end
            nchk++;
            if (obs[0].d !== 36'o123456701234) begin nerr++; $display("FAIL arx_data: got %o required 123456701234", obs[0].d); end
            nchk++;
            if (obs[0].s !== 3'd5) begin nerr++; $display("FAIL arx_sel: got %0d required 5", obs[0].s); end
        end
        nchk++;
        if (dones.size() != 1 || dones[0] - c0 != 7)
            begin nerr++; $display("FAIL arx_done: got %0d pulses first %0d required 1 at 7", dones.size(), dones.size() ? dones[0] - c0 : -1); end
        nchk++;
        if (idle_at - c0 != 8) begin nerr++; $display("FAIL arx_idle: got %0d required 8", idle_at - c0); end
        nchk++;
        if (dsel !== 3'd5 || dfg !== 4'b0101) begin nerr++; $display("FAIL arx_diag: got %b/%0d required 0101/5", dfg, dsel); end
    endtask

    task automatic test_random_single;
        wmode = 2;
        for (int r = 0; r < 6; r++) begin
            logic [2:0] s = 3'($urandom);
            for (int i = 0; i < 8; i++) begin kv[i] = $urandom_range(1, 4); rw[i] = {4'($urandom), $urandom}; end
            run(1'b0, s, 1'b0, -1);
            predict(1'b0, s);
            nchk++;
            if (obs.size() != 1 || obs[0].c != expq[0].c || obs[0].s !== expq[0].s || obs[0].d !== expq[0].d) begin
                nerr++;
                $display("FAIL rand_single%0d: got n%0d c%0d s%0d %o required c%0d s%0d %o", r, obs.size(),
                         obs.size() ? obs[0].c - c0 : -1, obs.size() ? obs[0].s : 3'd0, obs.size() ? obs[0].d : 36'd0,
                         expq[0].c - c0, expq[0].s, expq[0].d);
            end
            nchk++;
            if (dones.size() != 1 || dones[0] != exp_done || idle_at != exp_idle || rdData !== expq[0].d) begin
                nerr++;
                $display("FAIL rand_single%0d_end: got done n%0d idle %0d data %o required done %0d idle %0d data %o", r,
                         dones.size(), idle_at - c0, rdData, exp_done - c0, exp_idle - c0, expq[0].d);
            end
        end
    endtask

    task automatic test_sweep;
        wmode = 1;
        for (int i = 0; i < 8; i++) kv[i] = $urandom_range(1, 4);
        run(1'b1, 3'($urandom), 1'b0, -1);
        predict(1'b1, 3'd0);
        nchk++;
        if (obs.size() != 8) begin nerr++; $display("FAIL sweep_count: got %0d required 8", obs.size()); end
        foreach (expq[j]) if (j < obs.size()) begin
            nchk++;
            if (obs[j].c != expq[j].c || obs[j].s !== expq[j].s || obs[j].d !== expq[j].d) begin
                nerr++;
                $display("FAIL sweep_ev%0d: got c%0d s%0d %o required c%0d s%0d %o", j,
                         obs[j].c - c0, obs[j].s, obs[j].d, expq[j].c - c0, expq[j].s, expq[j].d);
            end
        end
        nchk++;
        if (dones.size() != 1 || dones[0] != exp_done)
            begin nerr++; $display("FAIL sweep_done: got %0d pulses first %0d required 1 at %0d", dones.size(), dones.size() ? dones[0] - c0 : -1, exp_done - c0); end
        nchk++;
        if (dz != 8) begin nerr++; $display("FAIL sweep_gap: got %0d diag-idle cycles required 8", dz); end
    endtask

    task automatic test_timeout;
        logic [2:0] s = 3'($urandom);
        no_drive = 1'b1;
        run(1'b0, s, 1'b0, -1);
        predict(1'b0, s);
        nchk++;
        if (shi != TMO) begin nerr++; $display("FAIL tmo_strobe: got %0d cycles required %0d", shi, TMO); end
        nchk++;
        if (obs.size() != 0) begin nerr++; $display("FAIL tmo_rdvalid: got %0d pulses required 0", obs.size()); end
        nchk++;
        if (dones.size() != 1 || dones[0] != exp_done || idle_at != exp_idle)
            begin nerr++; $display("FAIL tmo_done: got n%0d idle %0d required done %0d idle %0d", dones.size(), idle_at - c0, exp_done - c0, exp_idle - c0); end
        nchk++;
        if (timeoutErr !== 1'b1) begin nerr++; $display("FAIL tmo_err: got %b required 1", timeoutErr); end
        no_drive = 1'b0;
        run(1'b0, SEL_BR, 1'b0, -1);
        predict(1'b0, SEL_BR);
        nchk++;
        if (terr0 !== 1'b0 || timeoutErr !== 1'b0)
            begin nerr++; $display("FAIL tmo_clear: got %b/%b required 0/0", terr0, timeoutErr); end
        nchk++;
        if (obs.size() != 1 || obs[0].d !== expq[0].d) begin nerr++; $display("FAIL tmo_recover: got n%0d required 1", obs.size()); end
    endtask

    task automatic test_drop;
        wmode = 1;
        drop_sel = 3;
        for (int i = 0; i < 8; i++) kv[i] = $urandom_range(1, 4);
        run(1'b1, 3'd0, 1'b0, -1);
        predict(1'b1, 3'd0);
        drop_sel = -1;
        nchk++;
        if (obs.size() != 3) begin nerr++; $display("FAIL drop_count: got %0d required 3", obs.size()); end
        foreach (expq[j]) if (j < obs.size()) begin
            nchk++;
            if (obs[j].c != expq[j].c || obs[j].s !== expq[j].s || obs[j].d !== expq[j].d)
                begin nerr++; $display("FAIL drop_ev%0d: got c%0d s%0d required c%0d s%0d", j, obs[j].c - c0, obs[j].s, expq[j].c - c0, expq[j].s); end
        end
        nchk++;
        if (dones.size() != 1 || dones[0] != exp_done || timeoutErr !== 1'b1 || idle_at != exp_idle)
            begin nerr++; $display("FAIL drop_end: got n%0d err %b idle %0d required done %0d err 1 idle %0d", dones.size(), timeoutErr, idle_at - c0, exp_done - c0, exp_idle - c0); end
    endtask

    task automatic test_reset_mid;
        int nd = 0;
        bit hit = 1'b0;
        for (int i = 0; i < 8; i++) kv[i] = 1;
        @(negedge clk);
        req = 1'b1; sweep = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = diagReadFunc12X && diag[4:6] == 3'd2;
        end
        nchk++;
        if (!hit) begin nerr++; $display("FAIL rst_mid_reach: strobe of selector 2 got 0 required 1"); end
        #1 reset = 1'b1;
        #1;
        nchk++;
        if (diagReadFunc12X !== 1'b0 || diag !== '0 || busy !== 1'b0)
            begin nerr++; $display("FAIL rst_mid_async: got strobe %b diag %b busy %b required 0", diagReadFunc12X, diag, busy); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = 1'b0;
            if (done) nd++;
        end
        nchk++;
        if (nd != 0) begin nerr++; $display("FAIL rst_mid_done: got %0d pulses required 0", nd); end
        run(1'b0, SEL_AD, 1'b0, -1);
        predict(1'b0, SEL_AD);
        nchk++;
        if (obs.size() != 1 || obs[0].s !== 3'd7 || obs[0].d !== expq[0].d || obs[0].c != expq[0].c || dones.size() != 1)
            begin nerr++; $display("FAIL rst_mid_after: got n%0d s%0d done n%0d required 1 s7 done 1", obs.size(), obs.size() ? obs[0].s : 3'd0, dones.size()); end
    endtask

    task automatic test_ignore_busy;
        wmode = 2;
        for (int i = 0; i < 8; i++) rw[i] = {4'($urandom), $urandom};
        run(1'b0, SEL_MQ, 1'b0, 3);
        predict(1'b0, SEL_MQ);
        nchk++;
        if (obs.size() != 1 || obs[0].s !== SEL_MQ || obs[0].d !== expq[0].d || dones.size() != 1 || idle_at != exp_idle)
            begin nerr++; $display("FAIL ignore_busy: got n%0d s%0d done n%0d idle %0d required 1 s2 done 1 idle %0d", obs.size(), obs.size() ? obs[0].s : 3'd0, dones.size(), idle_at - c0, exp_idle - c0); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] s = 3'($urandom);
        wmode = 2;
        for (int i = 0; i < 8; i++) begin kv[i] = $urandom_range(1, 4); rw[i] = {4'($urandom), $urandom}; end
        run(1'b0, 3'($urandom), 1'b0, -1);
        run(1'b0, s, 1'b1, -1);
        predict(1'b0, s);
        nchk++;
        if (obs.size() != 1 || obs[0].c != expq[0].c || obs[0].d !== expq[0].d || dones.size() != 1 || dones[0] != exp_done)
            begin nerr++; $display("FAIL back_to_back: got n%0d c%0d required c%0d", obs.size(), obs.size() ? obs[0].c - c0 : -1, expq[0].c - c0); end
    endtask

    initial begin
        nchk = 0; nerr = 0;
        test_reset();
        test_single_arx();
        test_random_single();
        test_sweep();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_ignore_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
